ps2_synth_keymap: RTL and testbench
===================================

// Module: ps2_synth_keymap
// PURPOSE
//  Turns the PS/2 receiver's scan-code byte stream into synth control signals:
//  a held note (note_in/note), octave +/- pulses, the ADSR field select, and ADSR +/- pulses.
//  Sits between the PS/2 byte receiver (upstream) and the settings registers / ALU controller.
//  It owns make/break (F0) and extended (E0) prefix handling, so downstream sees only clean events.
// PARAMETERS
//  TIMEOUT_CYCLES  default 2_500_000  max clk cycles a prefix state may wait for its next byte (50 ms @ 50 MHz)
//  TO_W            default 22         width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk                 in   1  system clock (CLOCK_50)
//  reset               in   1  synchronous, active-low
//  ps2_byte            in   8  received scan-code byte
//  ps2_byte_valid      in   1  1-cycle strobe; ps2_byte valid this cycle; back-to-back strobes allowed
//  note_in             out  1  high while the current note key is held
//  note                out  4  current note index 0..11 (C..B)
//  octave_plus_plus    out  1  1-cycle pulse: octave up
//  octave_minus_minus  out  1  1-cycle pulse: octave down
//  ADSR_selector       out  3  0 amp, 1 attack, 2 decay, 3 sustain, 4 release; level, held
//  ADSR_plus_plus      out  1  1-cycle pulse: selected field up
//  ADSR_minus_minus    out  1  1-cycle pulse: selected field down
//  last_code           out  8  last non-prefix byte accepted (debug, for LEDR/HEX)
// BEHAVIOUR
//  Reset (reset==0 at posedge): all outputs 0, FSM to IDLE, timeout counter 0; strobes during reset are ignored.
//  Every output is registered. An event shows on outputs 1 cycle after its strobe. Pulses last exactly 1 cycle.
//  FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
//   IDLE: F0->BRK; E0->EXT; any other byte -> MAKE(byte), stay IDLE.
//   BRK:  E0->EXT; F0->BRK (re-arm); other -> BREAK(byte), ->IDLE.
//   EXT:  F0->EXT_BRK; other -> discard, ->IDLE.
//   EXT_BRK: any byte -> discard, ->IDLE. Extended keys (arrows etc.) produce no events.
//   Non-IDLE states: the counter increments each cycle with no strobe and clears on a strobe.
//    When it reaches TIMEOUT_CYCLES the FSM returns to IDLE. No event is produced and the pending prefix is lost.
//  Key map (set 2): notes A1C=0 W1D=1 S1B=2 E24=3 D23=4 F2B=5 T2C=6 G34=7 Y35=8 H33=9 U3C=10 J3B=11;
//   octave Z1A=minus X22=plus; select 1:16=0 2:1E=1 3:26=2 4:25=3 5:2E=4; ADSR '-'4E=minus '='55=plus.
//  MAKE(note k): note<=k, note_in<=1. Applies even if another note is held (last key wins, legato).
//   A typematic repeat of the held note leaves everything unchanged.
//  BREAK(note k): if note_in && note==k then note_in<=0 and note keeps k. Otherwise ignored (a stale key is released).
//  MAKE(octave/ADSR +/-): one pulse per make code, including typematic repeats, so holding the key ramps.
//   BREAK of these keys: ignored.
//  MAKE(select n): ADSR_selector<=n. BREAK: ignored. Unmapped codes: no event, but last_code still updates.
//  At most one pulse output is high in any cycle (one byte per strobe).
//  last_code updates on MAKE and BREAK bytes only; prefix bytes never update it.
//  Reset mid-sequence (e.g. after F0) returns to IDLE, so the next byte is decoded as a fresh make.
// STRUCTURE
//  Shared include synth_keys.vh: scan-code localparams (KEY_A..KEY_EQ, PFX_BRK=8'hF0, PFX_EXT=8'hE0),
//   FSM state encodings, and the ADSR_SEL_* codes also used by the settings register bank.
//  Sub-module ps2_scan_lut (combinational): code[7:0] -> {cls[2:0] (NONE/NOTE/OCT_UP/OCT_DN/SEL/ADJ_UP/ADJ_DN), val[3:0]}.
//  Top level: FSM + timeout counter + output registers.
// TESTING
//  1C strobe -> next cycle note_in=1, note=0, last_code=1C. Then F0,1C -> note_in=0, note stays 0.
//  1C then 1D, then F0 1C -> note=1 and note_in stays 1. Then F0 1D -> note_in=0.
//  55,55,55 strobes on consecutive cycles -> ADSR_plus_plus high for 3 consecutive cycles. F0 55 -> no pulse.
//  26 -> ADSR_selector=2. Then E0 75, E0 F0 75 -> no outputs change, FSM back in IDLE.
//  F0, then no strobe for TIMEOUT_CYCLES (set to 16 in the bench), then 1C -> note_in=1 (treated as make).
//  F0, then reset low 1 cycle, then 22 -> octave_plus_plus pulses once. All outputs 0 the cycle after reset.

Source files
------------

// File: rtl/ps2_synth_keymap_pkg.sv
// Shared scan-code constants, FSM encodings, ADSR field codes and the key class type
// used by the PS/2 keymap and the settings register bank.
package ps2_synth_keymap_pkg;

  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] PFX_EXT = 8'hE0;

  localparam logic [7:0] KEY_A  = 8'h1C;
  localparam logic [7:0] KEY_W  = 8'h1D;
  localparam logic [7:0] KEY_S  = 8'h1B;
  localparam logic [7:0] KEY_E  = 8'h24;
  localparam logic [7:0] KEY_D  = 8'h23;
  localparam logic [7:0] KEY_F  = 8'h2B;
  localparam logic [7:0] KEY_T  = 8'h2C;
  localparam logic [7:0] KEY_G  = 8'h34;
  localparam logic [7:0] KEY_Y  = 8'h35;
  localparam logic [7:0] KEY_H  = 8'h33;
  localparam logic [7:0] KEY_U  = 8'h3C;
  localparam logic [7:0] KEY_J  = 8'h3B;
  localparam logic [7:0] KEY_Z  = 8'h1A;
  localparam logic [7:0] KEY_X  = 8'h22;
  localparam logic [7:0] KEY_1  = 8'h16;
  localparam logic [7:0] KEY_2  = 8'h1E;
  localparam logic [7:0] KEY_3  = 8'h26;
  localparam logic [7:0] KEY_4  = 8'h25;
  localparam logic [7:0] KEY_5  = 8'h2E;
  localparam logic [7:0] KEY_MI = 8'h4E;
  localparam logic [7:0] KEY_EQ = 8'h55;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [2:0] ADSR_SEL_AMP = 3'd0;
  localparam logic [2:0] ADSR_SEL_ATK = 3'd1;
  localparam logic [2:0] ADSR_SEL_DEC = 3'd2;
  localparam logic [2:0] ADSR_SEL_SUS = 3'd3;
  localparam logic [2:0] ADSR_SEL_REL = 3'd4;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_NOTE,
    CLS_OCT_UP,
    CLS_OCT_DN,
    CLS_SEL,
    CLS_ADJ_UP,
    CLS_ADJ_DN
  } key_cls_e;

endpackage

// File: rtl/ps2_synth_keymap_scan_lut.sv
// Combinational set-2 scan-code classifier: byte -> key class and class-local value.
module ps2_scan_lut
  import ps2_synth_keymap_pkg::*;
(
  input  logic [7:0] code_i,
  output key_cls_e   cls_o,
  output logic [3:0] val_o
);

  always_comb begin
    cls_o = CLS_NONE;
    val_o = '0;
    case (code_i)
      KEY_A:  begin cls_o = CLS_NOTE;   val_o = 4'd0;  end
      KEY_W:  begin cls_o = CLS_NOTE;   val_o = 4'd1;  end
      KEY_S:  begin cls_o = CLS_NOTE;   val_o = 4'd2;  end
      KEY_E:  begin cls_o = CLS_NOTE;   val_o = 4'd3;  end
      KEY_D:  begin cls_o = CLS_NOTE;   val_o = 4'd4;  end
      KEY_F:  begin cls_o = CLS_NOTE;   val_o = 4'd5;  end
      KEY_T:  begin cls_o = CLS_NOTE;   val_o = 4'd6;  end
      KEY_G:  begin cls_o = CLS_NOTE;   val_o = 4'd7;  end
      KEY_Y:  begin cls_o = CLS_NOTE;   val_o = 4'd8;  end
      KEY_H:  begin cls_o = CLS_NOTE;   val_o = 4'd9;  end
      KEY_U:  begin cls_o = CLS_NOTE;   val_o = 4'd10; end
      KEY_J:  begin cls_o = CLS_NOTE;   val_o = 4'd11; end
      KEY_Z:  cls_o = CLS_OCT_DN;
      KEY_X:  cls_o = CLS_OCT_UP;
      KEY_1:  begin cls_o = CLS_SEL;    val_o = {1'b0, ADSR_SEL_AMP}; end
      KEY_2:  begin cls_o = CLS_SEL;    val_o = {1'b0, ADSR_SEL_ATK}; end
      KEY_3:  begin cls_o = CLS_SEL;    val_o = {1'b0, ADSR_SEL_DEC}; end
      KEY_4:  begin cls_o = CLS_SEL;    val_o = {1'b0, ADSR_SEL_SUS}; end
      KEY_5:  begin cls_o = CLS_SEL;    val_o = {1'b0, ADSR_SEL_REL}; end
      KEY_MI: cls_o = CLS_ADJ_DN;
      KEY_EQ: cls_o = CLS_ADJ_UP;
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_synth_keymap.sv
// PS/2 scan-code stream to synth controls: F0/E0 prefix FSM with prefix timeout,
// note hold tracking, octave/ADSR pulses and ADSR field select. All outputs registered.
module ps2_synth_keymap
  import ps2_synth_keymap_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned TO_W           = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic       note_in,
  output logic [3:0] note,
  output logic       octave_plus_plus,
  output logic       octave_minus_minus,
  output logic [2:0] ADSR_selector,
  output logic       ADSR_plus_plus,
  output logic       ADSR_minus_minus,
  output logic [7:0] last_code
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            note_in_q, note_in_d;
  logic [3:0]      note_q, note_d;
  logic            oct_up_q, oct_up_d, oct_dn_q, oct_dn_d;
  logic [2:0]      sel_q, sel_d;
  logic            adj_up_q, adj_up_d, adj_dn_q, adj_dn_d;
  logic [7:0]      last_q, last_d;

  key_cls_e   cls;
  logic [3:0] val;
  logic       make_ev, brk_ev;

  ps2_scan_lut u_lut (
    .code_i (ps2_byte),
    .cls_o  (cls),
    .val_o  (val)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    note_in_d = note_in_q;
    note_d    = note_q;
    sel_d     = sel_q;
    last_d    = last_q;
    oct_up_d  = 1'b0;
    oct_dn_d  = 1'b0;
    adj_up_d  = 1'b0;
    adj_dn_d  = 1'b0;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;

    if (ps2_byte_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (ps2_byte == PFX_BRK)      state_d = ST_BRK;
          else if (ps2_byte == PFX_EXT) state_d = ST_EXT;
          else                          make_ev = 1'b1;
        end
        ST_BRK: begin
          if (ps2_byte == PFX_EXT)      state_d = ST_EXT;
          else if (ps2_byte == PFX_BRK) state_d = ST_BRK;
          else begin
            brk_ev  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_EXT:  state_d = (ps2_byte == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // The cycle that would bring the count to TIMEOUT_CYCLES abandons the prefix.
      if (cnt_q == TO_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (make_ev || brk_ev) last_d = ps2_byte;

    if (make_ev) begin
      case (cls)
        CLS_NOTE: begin
          note_d    = val;
          note_in_d = 1'b1;
        end
        CLS_OCT_UP: oct_up_d = 1'b1;
        CLS_OCT_DN: oct_dn_d = 1'b1;
        CLS_SEL:    sel_d    = val[2:0];
        CLS_ADJ_UP: adj_up_d = 1'b1;
        CLS_ADJ_DN: adj_dn_d = 1'b1;
        default: ;
      endcase
    end

    // Only releasing the sounding note ends it; stale releases are dropped.
    if (brk_ev && cls == CLS_NOTE && note_in_q && note_q == val) note_in_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      note_in_q <= 1'b0;
      note_q    <= '0;
      oct_up_q  <= 1'b0;
      oct_dn_q  <= 1'b0;
      sel_q     <= '0;
      adj_up_q  <= 1'b0;
      adj_dn_q  <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      note_in_q <= note_in_d;
      note_q    <= note_d;
      oct_up_q  <= oct_up_d;
      oct_dn_q  <= oct_dn_d;
      sel_q     <= sel_d;
      adj_up_q  <= adj_up_d;
      adj_dn_q  <= adj_dn_d;
      last_q    <= last_d;
    end
  end

  assign note_in            = note_in_q;
  assign note               = note_q;
  assign octave_plus_plus   = oct_up_q;
  assign octave_minus_minus = oct_dn_q;
  assign ADSR_selector      = sel_q;
  assign ADSR_plus_plus     = adj_up_q;
  assign ADSR_minus_minus   = adj_dn_q;
  assign last_code          = last_q;

endmodule

// File: tb/tb_ps2_synth_keymap.sv
// Self-checking bench for ps2_synth_keymap: directed vector table, hand-written
// timeout/reset sequences, and randomized traffic against a prefix-queue reference model.
module tb_ps2_synth_keymap;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ps2_byte = '0;
  logic       ps2_byte_valid = 1'b0;
  logic       note_in;
  logic [3:0] note;
  logic       octave_plus_plus, octave_minus_minus;
  logic [2:0] ADSR_selector;
  logic       ADSR_plus_plus, ADSR_minus_minus;
  logic [7:0] last_code;

  int checks = 0;
  int errors = 0;

  ps2_synth_keymap #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .ps2_byte           (ps2_byte),
    .ps2_byte_valid     (ps2_byte_valid),
    .note_in            (note_in),
    .note               (note),
    .octave_plus_plus   (octave_plus_plus),
    .octave_minus_minus (octave_minus_minus),
    .ADSR_selector      (ADSR_selector),
    .ADSR_plus_plus     (ADSR_plus_plus),
    .ADSR_minus_minus   (ADSR_minus_minus),
    .last_code          (last_code)
  );

  always #5 clk = ~clk;

  // {note_in, note, oct+, oct-, sel, adsr+, adsr-, last_code}
  logic [19:0] dut_outs;
  assign dut_outs = {note_in, note, octave_plus_plus, octave_minus_minus,
                     ADSR_selector, ADSR_plus_plus, ADSR_minus_minus, last_code};

  function automatic logic [19:0] pk(input logic ni, input logic [3:0] n, input logic op,
                                     input logic om, input logic [2:0] sel, input logic ap,
                                     input logic am, input logic [7:0] last);
    return {ni, n, op, om, sel, ap, am, last};
  endfunction

  task automatic chk(input string name, input logic [19:0] exp);
    checks++;
    if (dut_outs !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, dut_outs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] b);
    ps2_byte_valid = s;
    ps2_byte       = b;
    @(negedge clk);
  endtask

  // Reference model: pending prefix bytes kept as a queue, key map as plain tables.
  logic [7:0] pfx[$];
  int         gap;
  logic       m_ni, m_op, m_om, m_ap, m_am;
  logic [3:0] m_note;
  logic [2:0] m_sel;
  logic [7:0] m_last;

  function automatic void decode(input logic [7:0] b, output int kind, output int val);
    logic [7:0] nk[12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                           8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    logic [7:0] sk[5]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    kind = 0; val = 0;
    foreach (nk[i]) if (b == nk[i]) begin kind = 1; val = i; end
    foreach (sk[i]) if (b == sk[i]) begin kind = 4; val = i; end
    if (b == 8'h22) kind = 2;
    if (b == 8'h1A) kind = 3;
    if (b == 8'h55) kind = 5;
    if (b == 8'h4E) kind = 6;
  endfunction

  task automatic model_reset();
    pfx.delete(); gap = 0;
    m_ni = 0; m_op = 0; m_om = 0; m_ap = 0; m_am = 0;
    m_note = 0; m_sel = 0; m_last = 0;
  endtask

  task automatic model_step(input logic s, input logic [7:0] b);
    int kind, val;
    bit mk, bk;
    m_op = 0; m_om = 0; m_ap = 0; m_am = 0;
    mk = 0; bk = 0;
    if (!s) begin
      if (pfx.size() > 0) begin
        gap++;
        if (gap == TO) begin pfx.delete(); gap = 0; end
      end
      return;
    end
    gap = 0;
    if (pfx.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
      else mk = 1;
    end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
      if (b == 8'hE0) pfx[0] = 8'hE0;
      else if (b != 8'hF0) begin pfx.delete(); bk = 1; end
    end else if (pfx.size() == 1) begin
      if (b == 8'hF0) pfx.push_back(b);
      else pfx.delete();
    end else begin
      pfx.delete();
    end
    decode(b, kind, val);
    if (mk || bk) m_last = b;
    if (mk) begin
      case (kind)
        1: begin m_note = 4'(val); m_ni = 1; end
        2: m_op = 1;
        3: m_om = 1;
        4: m_sel = 3'(val);
        5: m_ap = 1;
        6: m_am = 1;
        default: ;
      endcase
    end
    if (bk && kind == 1 && m_ni && int'(m_note) == val) m_ni = 0;
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  b;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic [7:0] b, input logic [19:0] exp);
    vec_t v;
    v.s = s; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endfunction

  logic [7:0] pool[26] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
                           8'h33, 8'h3C, 8'h3B, 8'h1A, 8'h22, 8'h16, 8'h1E, 8'h26, 8'h25,
                           8'h2E, 8'h4E, 8'h55, 8'hF0, 8'hF0, 8'hE0, 8'h75, 8'h00};

  initial begin
    // Directed table: each row is one cycle of input and the outputs seen one cycle later.
    add(1, 8'h1C, pk(1,0,0,0,0,0,0,8'h1C));
    add(1, 8'hF0, pk(1,0,0,0,0,0,0,8'h1C));
    add(1, 8'h1C, pk(0,0,0,0,0,0,0,8'h1C));
    add(1, 8'h1C, pk(1,0,0,0,0,0,0,8'h1C));
    add(1, 8'h1D, pk(1,1,0,0,0,0,0,8'h1D));
    add(1, 8'hF0, pk(1,1,0,0,0,0,0,8'h1D));
    add(1, 8'h1C, pk(1,1,0,0,0,0,0,8'h1C));
    add(1, 8'hF0, pk(1,1,0,0,0,0,0,8'h1C));
    add(1, 8'h1D, pk(0,1,0,0,0,0,0,8'h1D));
    add(1, 8'h55, pk(0,1,0,0,0,1,0,8'h55));
    add(1, 8'h55, pk(0,1,0,0,0,1,0,8'h55));
    add(1, 8'h55, pk(0,1,0,0,0,1,0,8'h55));
    add(1, 8'hF0, pk(0,1,0,0,0,0,0,8'h55));
    add(1, 8'h55, pk(0,1,0,0,0,0,0,8'h55));
    add(0, 8'h00, pk(0,1,0,0,0,0,0,8'h55));
    add(1, 8'h26, pk(0,1,0,0,2,0,0,8'h26));
    add(1, 8'hE0, pk(0,1,0,0,2,0,0,8'h26));
    add(1, 8'h75, pk(0,1,0,0,2,0,0,8'h26));
    add(1, 8'hE0, pk(0,1,0,0,2,0,0,8'h26));
    add(1, 8'hF0, pk(0,1,0,0,2,0,0,8'h26));
    add(1, 8'h75, pk(0,1,0,0,2,0,0,8'h26));
    add(1, 8'h1A, pk(0,1,0,1,2,0,0,8'h1A));
    add(1, 8'h22, pk(0,1,1,0,2,0,0,8'h22));
    add(1, 8'h4E, pk(0,1,0,0,2,0,1,8'h4E));
    add(1, 8'h16, pk(0,1,0,0,0,0,0,8'h16));
    add(1, 8'h2E, pk(0,1,0,0,4,0,0,8'h2E));
    add(1, 8'hF0, pk(0,1,0,0,4,0,0,8'h2E));
    add(1, 8'hE0, pk(0,1,0,0,4,0,0,8'h2E));
    add(1, 8'h75, pk(0,1,0,0,4,0,0,8'h2E));
    add(1, 8'h1C, pk(1,0,0,0,4,0,0,8'h1C));
    add(1, 8'h00, pk(1,0,0,0,4,0,0,8'h00));
    add(1, 8'hF0, pk(1,0,0,0,4,0,0,8'h00));
    add(1, 8'hF0, pk(1,0,0,0,4,0,0,8'h00));
    add(1, 8'h3B, pk(1,0,0,0,4,0,0,8'h3B));
    add(1, 8'hF0, pk(1,0,0,0,4,0,0,8'h3B));
    add(1, 8'h1C, pk(0,0,0,0,4,0,0,8'h1C));

    // Reset held for a few cycles with strobes present; outputs must stay zero.
    ps2_byte_valid = 1'b1;
    ps2_byte       = 8'h1C;
    repeat (3) @(negedge clk);
    chk("reset_state", '0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s, vecs[i].b);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Prefix timeout: exactly TO idle cycles drops a pending F0.
    drive(1, 8'hF0);
    for (int i = 0; i < TO; i++) drive(0, 8'h00);
    drive(1, 8'h1C);
    chk("timeout_make", pk(1,0,0,0,4,0,0,8'h1C));

    // One cycle short of the timeout the F0 is still pending.
    drive(1, 8'hF0);
    for (int i = 0; i < TO - 1; i++) drive(0, 8'h00);
    drive(1, 8'h1C);
    chk("pre_timeout_break", pk(0,0,0,0,4,0,0,8'h1C));

    // Reset between F0 and the next byte.
    drive(1, 8'hF0);
    reset = 1'b0;
    drive(1, 8'h1C);
    chk("reset_mid_seq", '0);
    reset = 1'b1;
    drive(1, 8'h22);
    chk("post_reset_make", pk(0,0,1,0,0,0,0,8'h22));
    drive(0, 8'h00);
    chk("pulse_one_cycle", pk(0,0,0,0,0,0,0,8'h22));

    // Randomized traffic against the reference model.
    reset = 1'b0;
    drive(0, 8'h00);
    reset = 1'b1;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      logic       s;
      logic [7:0] b;
      if ($urandom_range(0, 39) == 0) begin
        int len = int'($urandom_range(TO - 3, TO + 4));
        for (int k = 0; k < len; k++) begin
          model_step(0, 8'h00);
          drive(0, 8'h00);
          chk("rand_gap", pk(m_ni, m_note, m_op, m_om, m_sel, m_ap, m_am, m_last));
        end
      end
      s = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 15) == 0) ? 8'($urandom) : pool[$urandom_range(0, 25)];
      model_step(s, b);
      drive(s, b);
      chk("rand", pk(m_ni, m_note, m_op, m_om, m_sel, m_ap, m_am, m_last));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
